// File: rtl/inv_key_schedule.sv
// inv_key_schedule: runs the AES key expansion backwards from the last NK words,
// emitting round keys NR down to 0 over a valid/ready handshake.
module inv_key_schedule #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [NK*32-1:0] last_key,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_round,
    output logic             done
);
    localparam logic [1:0] IDLE = 2'd0, DECIDE = 2'd1, STEP = 2'd2, EMIT = 2'd3;
    localparam logic [7:0] J_LAST = 8'(4 * (NR + 1) - NK);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                         8'h80, 8'h1b, 8'h36, 40'h0};

    logic [1:0]          state_q, state_d;
    logic [0:NK-1][31:0] win_q, win_d;
    logic [7:0]          j_q, j_d;
    logic [3:0]          r_q, r_d;
    logic                busy_q, busy_d, valid_q, valid_d, done_q, done_d;
    logic [127:0]        data_q, data_d;
    logic [3:0]          round_q, round_d;
    logic [7:0]          i_w, r4, off;
    logic [31:0]         t, t_f, new_w;
    logic [3:0]          rc_idx;
    logic [127:0]        emit_w;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    assign i_w    = j_q + 8'(NK - 1);
    assign r4     = {2'b00, r_q, 2'b00};
    assign off    = r4 - j_q;
    assign rc_idx = 4'(i_w / 8'(NK));
    assign t      = win_q[NK-2];
    // forward recurrence w[i] = w[i-NK] ^ f(w[i-1]) solved for its oldest term
    assign t_f    = (i_w % 8'(NK) == 8'd0) ? sub_word({t[23:0], t[31:24]}) ^ {RCON[rc_idx], 24'd0}
                  : (NK > 6 && i_w % 8'(NK) == 8'd4) ? sub_word(t) : t;
    assign new_w  = win_q[NK-1] ^ t_f;

    always_comb begin
        emit_w = win_q[0 +: 4];
        for (int k = 1; k <= NK - 4; k++) emit_w = (off == 8'(k)) ? win_q[k +: 4] : emit_w;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        j_d     = j_q;
        r_d     = r_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (load) begin
                win_d   = last_key;
                j_d     = J_LAST;
                r_d     = 4'(NR);
                busy_d  = 1'b1;
                state_d = DECIDE;
            end
            DECIDE: if (r4 >= j_q) begin
                data_d  = emit_w;
                round_d = r_q;
                valid_d = 1'b1;
                state_d = EMIT;
            end else state_d = STEP;
            STEP: begin
                win_d   = {new_w, win_q[0:NK-2]};
                j_d     = j_q - 8'd1;
                state_d = DECIDE;
            end
            default: if (rk_ready) begin
                valid_d = 1'b0;
                done_d  = (r_q == 4'd0);
                busy_d  = (r_q != 4'd0);
                r_d     = (r_q == 4'd0) ? r_q : r_q - 4'd1;
                state_d = (r_q == 4'd0) ? IDLE : DECIDE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            j_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            j_q     <= j_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            data_q  <= data_d;
            round_q <= round_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = valid_q;
    assign rk_data  = data_q;
    assign rk_round = round_q;
    assign done     = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: directed vectors plus an independent forward-expansion model
// for the AES-128/192/256 reverse key schedules.
module tb_inv_key_schedule;
    typedef struct { int nk; int r; logic [127:0] k; } vec_t;

    localparam logic [255:0] K128 = 256'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [255:0] K256 = 256'h4e5a6699a9f24fe07e572baacdf8cdea24fc79ccbf0979e9371ac23c6d68de36;

    logic         clk = 0, rst_n = 1, load = 0, rdy = 0;
    logic [255:0] last_key = '0;
    logic [1:0]   sel = 0;
    logic         busy_a [3], v_a [3], done_a [3];
    logic [127:0] d_a [3];
    logic [3:0]   r_a [3];
    logic         v_s, busy_s, done_s;
    logic [127:0] d_s;
    logic [3:0]   r_s;

    int           tests = 0, fails = 0;
    vec_t         tbl [14];
    logic [127:0] got_d [15];
    int           got_r [15];
    int           n_hs, first_cyc, stab;
    logic [31:0]  w_m [60];
    logic [7:0]   sbox_m [256];

    always #5 clk = ~clk;

    inv_key_schedule #(.NK(4), .NR(10)) u4 (
        .clk(clk), .rst_n(rst_n), .load(load && sel == 2'd0), .last_key(last_key[127:0]),
        .busy(busy_a[0]), .rk_valid(v_a[0]), .rk_ready(rdy && sel == 2'd0),
        .rk_data(d_a[0]), .rk_round(r_a[0]), .done(done_a[0]));
    inv_key_schedule #(.NK(6), .NR(12)) u6 (
        .clk(clk), .rst_n(rst_n), .load(load && sel == 2'd1), .last_key(last_key[191:0]),
        .busy(busy_a[1]), .rk_valid(v_a[1]), .rk_ready(rdy && sel == 2'd1),
        .rk_data(d_a[1]), .rk_round(r_a[1]), .done(done_a[1]));
    inv_key_schedule #(.NK(8), .NR(14)) u8 (
        .clk(clk), .rst_n(rst_n), .load(load && sel == 2'd2), .last_key(last_key),
        .busy(busy_a[2]), .rk_valid(v_a[2]), .rk_ready(rdy && sel == 2'd2),
        .rk_data(d_a[2]), .rk_round(r_a[2]), .done(done_a[2]));

    always_comb begin
        v_s    = v_a[sel];
        busy_s = busy_a[sel];
        done_s = done_a[sel];
        d_s    = d_a[sel];
        r_s    = r_a[sel];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse and affine map, independent of any table
    task automatic build_sbox();
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand(input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w_m[i-1];
            if (i % nk == 0) begin
                t  = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) t = sub_m(t);
            w_m[i] = w_m[i-nk] ^ t;
        end
    endtask

    function automatic logic [255:0] tail(input int nk, input int nr);
        logic [255:0] v;
        v = '0;
        for (int m = 0; m < nk; m++) v = {v[223:0], w_m[4*(nr+1)-nk+m]};
        return v;
    endfunction

    task automatic start(input logic [255:0] key);
        last_key = key;
        load = 1;
        @(negedge clk);
        load = 0;
    endtask

    // collects every handshake, optionally stalling and firing a stray load mid-run
    task automatic run(input int nr, input int stall_max, input logic [255:0] intruder);
        int cyc, left;
        logic stalled;
        logic [127:0] hd;
        logic [3:0] hr;
        cyc = 0; stalled = 0; hd = '0; hr = '0;
        left = $urandom_range(0, stall_max);
        n_hs = 0; first_cyc = -1; stab = 0;
        while (n_hs <= nr && cyc < 4000) begin
            if (stalled && (!v_s || d_s !== hd || r_s !== hr)) stab++;
            stalled = 0;
            load = (intruder != '0 && cyc == 6);
            if (load) last_key = intruder;
            if (v_s) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (left > 0) begin
                    rdy = 0; left--; stalled = 1; hd = d_s; hr = r_s;
                end else begin
                    rdy = 1;
                    got_d[n_hs] = d_s;
                    got_r[n_hs] = int'(r_s);
                    n_hs++;
                    left = $urandom_range(0, stall_max);
                end
            end else rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        rdy = 0; load = 0;
        chk("handshakes", 128'(n_hs), 128'(nr + 1));
        chk("first_valid_latency", 128'(first_cyc), 128'd1);
        chk("stall_stable", 128'(stab), 128'd0);
        chk("done_pulse", 128'(done_s), 128'd1);
        chk("busy_clear", 128'(busy_s), 128'd0);
        chk("valid_clear", 128'(v_s), 128'd0);
        @(negedge clk);
        chk("done_one_cycle", 128'(done_s), 128'd0);
    endtask

    task automatic verify_table(input int nk, input int nr);
        foreach (tbl[k])
            if (tbl[k].nk == nk)
                chk($sformatf("tbl_nk%0d_r%0d", nk, tbl[k].r), got_d[nr - tbl[k].r], tbl[k].k);
    endtask

    task automatic verify_model(input int nk, input int nr);
        int r;
        for (int k = 0; k <= nr; k++) begin
            r = nr - k;
            chk($sformatf("model_nk%0d_r%0d", nk, r), got_d[k],
                {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]});
            chk($sformatf("order_nk%0d_%0d", nk, k), 128'(got_r[k]), 128'(r));
        end
    endtask

    initial begin
        int cyc, bad;
        tbl = '{
            '{4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}, '{4, 9, 128'hac7766f319fadc2128d12941575c006e},
            '{4, 8, 128'head27321b58dbad2312bf5607f8d292f}, '{4, 7, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f},
            '{4, 6, 128'h6d88a37a110b3efddbf98641ca0093fd}, '{4, 5, 128'hd4d1c6f87c839d87caf2b8bc11f915bc},
            '{4, 4, 128'hef44a541a8525b7fb671253bdb0bad00}, '{4, 3, 128'h3d80477d4716fe3e1e237e446d7a883b},
            '{4, 2, 128'hf2c295f27a96b9435935807a7359f67f}, '{4, 1, 128'ha0fafe1788542cb123a339392a6c7605},
            '{4, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
            '{8, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36}, '{8, 13, 128'h4e5a6699a9f24fe07e572baacdf8cdea},
            '{8, 0, 128'h000102030405060708090a0b0c0d0e0f}
        };
        build_sbox();
        #1 rst_n = 0;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            chk($sformatf("reset_outputs_%0d", s), {busy_s, v_s, done_s, r_s, d_s[120:0]}, 128'd0);
            chk($sformatf("reset_data_%0d", s), d_s, 128'd0);
        end
        @(negedge clk) rst_n = 1;
        @(negedge clk);

        sel = 0;
        w_m[0] = 32'h2b7e1516; w_m[1] = 32'h28aed2a6; w_m[2] = 32'habf71588; w_m[3] = 32'h09cf4f3c;
        expand(4, 10);
        start(K128);
        run(10, 0, '0);
        verify_table(4, 10);
        verify_model(4, 10);

        sel = 2;
        for (int m = 0; m < 8; m++) w_m[m] = {8'(4*m), 8'(4*m+1), 8'(4*m+2), 8'(4*m+3)};
        expand(8, 14);
        start(K256);
        run(14, 0, '0);
        verify_table(8, 14);
        verify_model(8, 14);

        sel = 1;
        repeat (2) begin
            for (int m = 0; m < 6; m++) w_m[m] = $urandom;
            expand(6, 12);
            start(tail(6, 12));
            run(12, 10, '0);
            verify_model(6, 12);
        end

        sel = 0;
        start(K128);
        run(10, 10, 256'h000102030405060708090a0b0c0d0e0f);
        verify_table(4, 10);

        start(K128);
        cyc = 0;
        while (!(v_s && r_s == 4'd5) && cyc < 500) begin
            rdy = v_s;
            @(negedge clk);
            cyc++;
        end
        rdy = 0;
        chk("reach_round5", 128'(cyc < 500), 128'd1);
        #2 rst_n = 0;
        #1;
        chk("async_abort_ctrl", {busy_s, v_s, done_s, r_s}, 128'd0);
        chk("async_abort_data", d_s, 128'd0);
        @(negedge clk) rst_n = 1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (v_s || busy_s) bad++;
        end
        chk("no_partial_after_reset", 128'(bad), 128'd0);
        start(K128);
        run(10, 3, '0);
        verify_table(4, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
